// File: rtl/binarize_stream.sv
// Streaming pixel binariser with manual or frame-mean threshold and one output register stage.
// Define BINARIZE_AUTO_THRESH_EN to build the frame-mean accumulator, FSM and divider.
module binarize_stream #(
  parameter int               PIX_W       = 12,
  parameter int               CNT_W       = 20,
  parameter logic [PIX_W-1:0] THRESH_INIT = 12'h555
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] cfg_thresh,
  input  logic             cfg_auto,
  input  logic             cfg_invert,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_sof,
  input  logic             in_eof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_sof,
  output logic             out_eof,
  output logic [PIX_W-1:0] thr_cur,
  output logic             auto_busy
);

  logic             acc;
  logic [PIX_W-1:0] thr_next;
  logic [PIX_W-1:0] thr_sel;

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign thr_sel  = (acc && in_sof) ? thr_next : thr_cur;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      thr_cur   <= THRESH_INIT;
    end else begin
      if (acc) begin
        out_valid <= 1'b1;
        out_pixel <= {PIX_W{(in_pixel >= thr_sel) ^ cfg_invert}};
        out_sof   <= in_sof;
        out_eof   <= in_eof;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (acc && in_sof) thr_cur <= thr_next;
    end
  end

`ifdef BINARIZE_AUTO_THRESH_EN
  // state  | meaning
  // IDLE   | no measurement running
  // ACCUM  | summing pixels of the current frame
  // DIVIDE | restoring divide sum/cnt, one quotient bit per cycle
  // HOLD   | mean ready, applied on the next sof beat
  localparam int SUM_W  = PIX_W + CNT_W;
  localparam int DIV_CW = $clog2(SUM_W);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, HOLD} state_t;

  state_t            state, state_nxt;
  logic [SUM_W-1:0]  sum, sum_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CNT_W-1:0]  rem, rem_nxt;
  logic [DIV_CW-1:0] div_cnt, div_cnt_nxt;
  logic [PIX_W-1:0]  mean, mean_nxt;
  logic [CNT_W:0]    rem_sh;
  logic              q_bit;
  logic [SUM_W-1:0]  quo;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sum     <= '0;
      cnt     <= '0;
      rem     <= '0;
      div_cnt <= '0;
      mean    <= '0;
    end else begin
      state   <= state_nxt;
      sum     <= sum_nxt;
      cnt     <= cnt_nxt;
      rem     <= rem_nxt;
      div_cnt <= div_cnt_nxt;
      mean    <= mean_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sum_nxt     = sum;
    cnt_nxt     = cnt;
    rem_nxt     = rem;
    div_cnt_nxt = div_cnt;
    mean_nxt    = mean;
    // sum doubles as the quotient shift register while dividing
    rem_sh      = {rem, sum[SUM_W-1]};
    q_bit       = rem_sh >= {1'b0, cnt};
    quo         = {sum[SUM_W-2:0], q_bit};
    if (!cfg_auto) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, HOLD, ACCUM: begin
          if (acc && (in_sof || state == ACCUM)) begin
            if (in_sof) begin
              sum_nxt   = SUM_W'(in_pixel);
              cnt_nxt   = CNT_W'(1);
              state_nxt = ACCUM;
            end else if (cnt != '1) begin
              sum_nxt = sum + SUM_W'(in_pixel);
              cnt_nxt = cnt + CNT_W'(1);
            end
            if (in_eof) begin
              state_nxt   = DIVIDE;
              rem_nxt     = '0;
              div_cnt_nxt = DIV_CW'(SUM_W - 1);
            end
          end
        end
        DIVIDE: begin
          rem_nxt     = q_bit ? CNT_W'(rem_sh - {1'b0, cnt}) : CNT_W'(rem_sh);
          sum_nxt     = quo;
          div_cnt_nxt = div_cnt - DIV_CW'(1);
          if (div_cnt == '0) begin
            mean_nxt  = (|quo[SUM_W-1:PIX_W]) ? '1 : quo[PIX_W-1:0];
            state_nxt = HOLD;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign thr_next  = !cfg_auto ? cfg_thresh : (state == HOLD) ? mean : thr_cur;
  assign auto_busy = (state == DIVIDE);
`else
  logic [CNT_W:0] auto_unused;

  assign auto_unused = {(CNT_W + 1){cfg_auto}};
  assign thr_next    = cfg_thresh;
  assign auto_busy   = 1'b0;
`endif

endmodule

// File: doc/binarize_stream.md
BINARIZE_STREAM -- requirements
Module: binarize_stream

Interface
REQ-001 Parameter PIX_W, default 12, pixel width in bits.
REQ-002 Parameter CNT_W, default 20, width of the auto-threshold pixel counter.
REQ-003 Parameter THRESH_INIT, default 12'h555, threshold value loaded at reset.
REQ-004 clk  in  1  single clock, all logic on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 cfg_thresh  in  PIX_W  manual threshold.
REQ-007 cfg_auto  in  1  1 = auto (frame-mean) threshold, 0 = manual.
REQ-008 cfg_invert  in  1  swaps the output polarity.
REQ-009 in_valid / in_ready  in / out  1 / 1  input handshake.
REQ-010 in_pixel  in  PIX_W  gray pixel.
REQ-011 in_sof / in_eof  in  1 / 1  first / last pixel of frame, qualified by in_valid.
REQ-012 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-013 out_pixel  out  PIX_W  binary pixel, all-zeros or all-ones.
REQ-014 out_sof / out_eof  out  1 / 1  sideband, aligned to out_pixel.
REQ-015 thr_cur  out  PIX_W  threshold currently applied.
REQ-016 auto_busy  out  1  high while the mean divider runs.

Function
REQ-017 Beat transfer: a beat transfers when valid and ready are both high in the same cycle.
REQ-018 Input ready: in_ready SHALL equal !out_valid || out_ready, giving one output register stage.
REQ-019 Latency: latency from input beat to output SHALL be 1 cycle.
REQ-020 Output hold: out_pixel and the out sideband SHALL hold stable while out_valid && !out_ready.
REQ-021 Binarisation:
- out_pixel SHALL be all-zeros if pixel < thr_sel, otherwise all-ones.
- The result SHALL be inverted when cfg_invert = 1.
- cfg_invert is sampled per beat.
REQ-022 Threshold select:
- thr_sel SHALL be the next threshold on an accepted in_sof beat, and thr_cur otherwise.
- thr_cur SHALL load the next threshold on that beat.
- Thresholds change only at frame boundaries.
REQ-023 Next threshold:
- Manual mode: next threshold = cfg_thresh.
- Auto mode: next threshold = the pending mean if one is held, otherwise thr_cur unchanged.
REQ-024 Auto FSM states: IDLE, ACCUM, DIVIDE, HOLD.
REQ-025 IDLE -> ACCUM on an accepted sof beat: sum = pixel, cnt = 1.
REQ-026 In ACCUM, each accepted beat:
- SHALL add the pixel to sum and increment cnt.
- cnt saturates at 2^CNT_W-1; once saturated, sum stops accumulating.
REQ-027 ACCUM transitions:
- An accepted eof beat (included in the sum) -> DIVIDE.
- An accepted sof beat in ACCUM SHALL restart accumulation.
REQ-028 DIVIDE: restoring divider, sum/cnt truncated, PIX_W+CNT_W cycles, auto_busy = 1; result saturates to all-ones.
REQ-029 DIVIDE -> HOLD: the pending mean is stored.
REQ-030 HOLD transitions:
- HOLD -> ACCUM on the next accepted sof beat.
- The mean is consumed as the next threshold on that same beat.
REQ-031 A sof beat arriving during DIVIDE SHALL NOT be measured; that frame keeps the old thr_cur.
REQ-032 An eof beat in IDLE or HOLD SHALL be ignored; a single-beat frame (sof and eof together) yields mean = pixel.
REQ-033 cfg_auto = 0 SHALL force the FSM to IDLE and discard any pending mean.

Reset
REQ-034 Reset values while rst_n = 0 at a clock edge:
- out_valid = 0, out_pixel = 0, out_sof = 0, out_eof = 0.
- thr_cur = THRESH_INIT.
- FSM = IDLE, sum = cnt = 0, auto_busy = 0.
REQ-035 Reset mid-frame or mid-divide SHALL abandon all state; there is no partial output.

Configuration
REQ-036 With macro BINARIZE_AUTO_THRESH_EN defined, the block SHALL include the accumulator, FSM and divider.
REQ-037 With BINARIZE_AUTO_THRESH_EN undefined:
- cfg_auto SHALL be ignored and the block behaves as manual mode.
- auto_busy SHALL be tied to 0.
- No accumulator or divider logic is present.

Verification
REQ-038 Manual, PIX_W = 12, cfg_thresh = 0x555:
- pixels 0x554, 0x555, 0xFFF with out_ready = 1 -> 0x000, 0xFFF, 0xFFF, each 1 cycle later.
- With cfg_invert = 1 -> 0xFFF, 0x000, 0x000.
REQ-039 Backpressure:
- out_ready = 0 for 5 cycles while out_valid = 1 -> out_pixel held, in_ready = 0.
- Release -> no beat lost or duplicated across 100 random-stall beats.
REQ-040 Auto mode:
- Frame 1: 4 pixels 0x100, 0x200, 0x300, 0x401 -> auto_busy pulses, mean = 0x280.
- Frame 2: thr_cur = 0x280 from its sof beat; pixel 0x27F -> 0x000, pixel 0x280 -> 0xFFF.
REQ-041 Frame during divide:
- sof sent 2 cycles after eof -> that frame uses the old threshold and is not measured.
- The following frame uses frame 1's mean.
REQ-042 Manual threshold change:
- cfg_thresh changed mid-frame -> no effect until the next sof beat.
- Reset asserted mid-ACCUM -> thr_cur = 0x555, out_valid = 0 on the next cycle.
REQ-043 Macro undefined: cfg_auto = 1 with the REQ-040 stimulus -> threshold stays at cfg_thresh, auto_busy = 0.
